// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : RV32/RV64 immediate/format decoder feeding a 2-entry in-order
//            skid buffer carrying imm, format and sideband tag.
//            Optional macro IMMGEN_SHAMT_EN: shift-immediate ALU ops yield the
//            zero-extended shift amount instead of the plain I-type immediate.
// Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    input  logic             err_clr,
    output logic [15:0]      err_cnt
);

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_REG32  = 7'b0111011;

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [6:0]      w_opcode;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_push;
    logic            w_pop;

    assign w_opcode = in_instr[6:0];

    always_comb begin
        w_fmt = c_FMT_ILL;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: w_fmt = c_FMT_I;
            c_OP_STORE:                                  w_fmt = c_FMT_S;
            c_OP_BRANCH:                                 w_fmt = c_FMT_B;
            c_OP_LUI, c_OP_AUIPC:                        w_fmt = c_FMT_U;
            c_OP_JAL:                                    w_fmt = c_FMT_J;
            c_OP_REG, c_OP_REG32:                        w_fmt = c_FMT_R;
            default:                                     w_fmt = c_FMT_ILL;
        endcase
    end

`ifdef IMMGEN_SHAMT_EN
    localparam int c_SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic w_is_shift;
    assign w_is_shift = (w_opcode == c_OP_IMM) &&
                        ((in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101));
`endif

    // Signed casts to XLEN sign-extend from instr[31] in every format.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            c_FMT_I: w_imm = XLEN'($signed(in_instr[31:20]));
            c_FMT_S: w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            c_FMT_B: w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                            in_instr[11:8], 1'b0}));
            c_FMT_U: w_imm = XLEN'($signed({in_instr[31:12], 12'h000}));
            c_FMT_J: w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                            in_instr[30:21], 1'b0}));
            default: w_imm = '0;
        endcase
`ifdef IMMGEN_SHAMT_EN
        if (w_is_shift) begin
            w_imm = {{(XLEN-c_SHAMT_W){1'b0}}, in_instr[20 +: c_SHAMT_W]};
        end
`endif
    end

    // Slot 0 always holds the oldest entry and drives the outputs directly.
    logic [1:0]       r_cnt;
    logic [XLEN-1:0]  r_imm0;
    logic [XLEN-1:0]  r_imm1;
    logic [2:0]       r_fmt0;
    logic [2:0]       r_fmt1;
    logic [TAG_W-1:0] r_tag0;
    logic [TAG_W-1:0] r_tag1;
    logic [15:0]      r_err_cnt;

    assign in_ready  = (r_cnt != c_CNT_FULL);
    assign out_valid = (r_cnt != c_CNT_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= c_CNT_EMPTY;
            r_imm0 <= '0;
            r_imm1 <= '0;
            r_fmt0 <= c_FMT_R;
            r_fmt1 <= c_FMT_R;
            r_tag0 <= '0;
            r_tag1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == c_CNT_EMPTY) begin
                        r_imm0 <= w_imm;
                        r_fmt0 <= w_fmt;
                        r_tag0 <= in_tag;
                    end else begin
                        r_imm1 <= w_imm;
                        r_fmt1 <= w_fmt;
                        r_tag1 <= in_tag;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_imm0 <= r_imm1;
                    r_fmt0 <= r_fmt1;
                    r_tag0 <= r_tag1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry replaces the popped one.
                    if (r_cnt == c_CNT_ONE) begin
                        r_imm0 <= w_imm;
                        r_fmt0 <= w_fmt;
                        r_tag0 <= in_tag;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 16'h0000;
        end else if (err_clr) begin
            r_err_cnt <= 16'h0000;
        end else if (w_push && (w_fmt == c_FMT_ILL) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign out_imm = r_imm0;
    assign out_fmt = r_fmt0;
    assign out_tag = r_tag0;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed self-checking bench for imm_gen_pipe (XLEN 32 and 64).
// Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;
    logic        err_clr;
    logic [15:0] err_cnt;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;
    logic [15:0] err_cnt64;

    int n_chk;
    int n_pass;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_tag(out_tag),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    // Shares stimulus with the 32-bit instance; only its immediate is checked.
    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_tag(out_tag64),
        .err_clr(err_clr), .err_cnt(err_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({out_valid, in_ready, out_fmt, out_tag, out_imm, err_cnt} !== {1'b0, 1'b1, 3'd0, 8'd0, 32'd0, 16'd0})
            $display("FAIL reset_state: got v=%b rdy=%b fmt=%0d tag=%h imm=%h err=%h expected 0/1/0/00/0/0",
                     out_valid, in_ready, out_fmt, out_tag, out_imm, err_cnt);
        else n_pass++;
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hE070_0013;
        in_tag    = 8'hA5;
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({out_valid, out_fmt, out_tag, out_imm} !== {1'b1, 3'd1, 8'hA5, 32'hFFFF_FE07})
            $display("FAIL itype_neg: got v=%b fmt=%0d tag=%h imm=%h expected v=1 fmt=1 tag=a5 imm=fffffe07",
                     out_valid, out_fmt, out_tag, out_imm);
        else n_pass++;
        step();
        n_chk++;
        if (out_valid !== 1'b0)
            $display("FAIL itype_drain: got out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [5];
        logic [31:0] imms   [5];
        logic [2:0]  fmts   [5];
        instrs = '{32'h0000_0163, 32'h8000_0063, 32'h1234_5037, 32'h0040_006F, 32'h0200_0033};
        imms   = '{32'h0000_0002, 32'hFFFF_F000, 32'h1234_5000, 32'h0000_0004, 32'h0000_0000};
        fmts   = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = instrs[i];
            in_tag   = 8'(i + 1);
            step();
            n_chk++;
            if ({out_valid, in_ready, out_fmt, out_tag, out_imm} !== {1'b1, 1'b1, fmts[i], 8'(i + 1), imms[i]})
                $display("FAIL b2b_%0d: got v=%b rdy=%b fmt=%0d tag=%0d imm=%h expected v=1 rdy=1 fmt=%0d tag=%0d imm=%h",
                         i, out_valid, in_ready, out_fmt, out_tag, out_imm, fmts[i], i + 1, imms[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_chk++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0010_0013;
        in_tag    = 8'd10;
        step();
        n_chk++;
        if ({in_ready, out_valid, out_tag, out_imm} !== {1'b1, 1'b1, 8'd10, 32'd1})
            $display("FAIL stall_first: got rdy=%b v=%b tag=%0d imm=%h expected rdy=1 v=1 tag=10 imm=1",
                     in_ready, out_valid, out_tag, out_imm);
        else n_pass++;
        in_instr = 32'h0020_0013;
        in_tag   = 8'd11;
        step();
        n_chk++;
        if ({in_ready, out_valid, out_tag, out_imm} !== {1'b0, 1'b1, 8'd10, 32'd1})
            $display("FAIL stall_full: got rdy=%b v=%b tag=%0d imm=%h expected rdy=0 v=1 tag=10 imm=1",
                     in_ready, out_valid, out_tag, out_imm);
        else n_pass++;
        in_instr = 32'h0030_0013;
        in_tag   = 8'd12;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++;
            if ({in_ready, out_valid, out_fmt, out_tag, out_imm} !== {1'b0, 1'b1, 3'd1, 8'd10, 32'd1})
                $display("FAIL stall_hold_%0d: got rdy=%b v=%b fmt=%0d tag=%0d imm=%h expected rdy=0 v=1 fmt=1 tag=10 imm=1",
                         i, in_ready, out_valid, out_fmt, out_tag, out_imm);
            else n_pass++;
        end
        out_ready = 1'b1;
        step();
        n_chk++;
        if ({in_ready, out_valid, out_tag, out_imm} !== {1'b1, 1'b1, 8'd11, 32'd2})
            $display("FAIL stall_second: got rdy=%b v=%b tag=%0d imm=%h expected rdy=1 v=1 tag=11 imm=2",
                     in_ready, out_valid, out_tag, out_imm);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({in_ready, out_valid, out_tag, out_imm} !== {1'b1, 1'b1, 8'd12, 32'd3})
            $display("FAIL stall_third: got rdy=%b v=%b tag=%0d imm=%h expected rdy=1 v=1 tag=12 imm=3",
                     in_ready, out_valid, out_tag, out_imm);
        else n_pass++;
        step();
        n_chk++;
        if (out_valid !== 1'b0)
            $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_shamt_and_xlen64();
        logic [31:0] exp_srai;
`ifdef IMMGEN_SHAMT_EN
        exp_srai = 32'h0000_0003;
`else
        exp_srai = 32'h0000_0403;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h4030_D093;
        in_tag    = 8'h21;
        step();
        n_chk++;
        if ({out_fmt, out_imm} !== {3'd1, exp_srai})
            $display("FAIL srai_imm: got fmt=%0d imm=%h expected fmt=1 imm=%h", out_fmt, out_imm, exp_srai);
        else n_pass++;
        in_instr = 32'hFFF0_0013;
        in_tag   = 8'h22;
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({out_valid64, out_fmt64, out_imm64} !== {1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF})
            $display("FAIL xlen64_itype: got v=%b fmt=%0d imm=%h expected v=1 fmt=1 imm=ffffffffffffffff",
                     out_valid64, out_fmt64, out_imm64);
        else n_pass++;
        n_chk++;
        if (out_imm !== 32'hFFFF_FFFF)
            $display("FAIL xlen32_minus1: got imm=%h expected ffffffff", out_imm);
        else n_pass++;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        words = '{32'h0000_0000, 32'h1234_5600, 32'hFFFF_FF80};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            in_tag   = 8'(8'h30 + i);
            step();
            n_chk++;
            if ({out_valid, out_fmt, out_imm, err_cnt} !== {1'b1, 3'd7, 32'd0, 16'(i + 1)})
                $display("FAIL illegal_%0d: got v=%b fmt=%0d imm=%h err=%0d expected v=1 fmt=7 imm=0 err=%0d",
                         i, out_valid, out_fmt, out_imm, err_cnt, i + 1);
            else n_pass++;
        end
        in_instr = 32'h0000_0000;
        err_clr  = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if ({err_cnt, out_fmt} !== {16'd0, 3'd7})
            $display("FAIL err_clr_priority: got err=%0d fmt=%0d expected err=0 fmt=7", err_cnt, out_fmt);
        else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0000;
        in_tag    = 8'h41;
        step();
        in_instr  = 32'h0010_0013;
        in_tag    = 8'h42;
        step();
        in_valid  = 1'b0;
        n_chk++;
        if ({out_valid, in_ready, err_cnt} !== {1'b1, 1'b0, 16'd1})
            $display("FAIL prereset_full: got v=%b rdy=%b err=%0d expected v=1 rdy=0 err=1",
                     out_valid, in_ready, err_cnt);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, in_ready, err_cnt, out_imm, out_tag, out_fmt} !== {1'b0, 1'b1, 16'd0, 32'd0, 8'd0, 3'd0})
            $display("FAIL async_reset: got v=%b rdy=%b err=%0d imm=%h tag=%h fmt=%0d expected 0/1/0/0/0/0",
                     out_valid, in_ready, err_cnt, out_imm, out_tag, out_fmt);
        else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (out_valid !== 1'b0)
                $display("FAIL stale_after_reset_%0d: got out_valid=%b expected 0", i, out_valid);
            else n_pass++;
        end
        in_valid = 1'b1;
        in_instr = 32'h0050_0013;
        in_tag   = 8'h55;
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({out_valid, out_tag, out_imm} !== {1'b1, 8'h55, 32'd5})
            $display("FAIL post_reset_push: got v=%b tag=%h imm=%h expected v=1 tag=55 imm=5",
                     out_valid, out_tag, out_imm);
        else n_pass++;
        step();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_tag    = 8'h0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        test_reset();
        test_itype();
        test_back_to_back();
        test_stall();
        test_shamt_and_xlen64();
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 8, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream offers instruction.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 in_instr  input  32  RV32/RV64 base instruction word.
REQ-008 in_tag  input  TAG_W  opaque tag (e.g. PC index).
REQ-009 out_valid  output  1  decoded entry available.
REQ-010 out_ready  input  1  downstream accepts entry.
REQ-011 out_imm  output  XLEN  sign/zero-extended immediate.
REQ-012 out_fmt  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=ILLEGAL.
REQ-013 out_tag  output  TAG_W  tag of the entry on out_imm.
REQ-014 err_clr  input  1  synchronous clear of err_cnt.
REQ-015 err_cnt  output  16  count of accepted ILLEGAL opcodes.

Function
REQ-016 SHALL decode opcode in_instr[6:0]: 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011/0111011 -> R; all others -> ILLEGAL.
REQ-017 I: imm = sext(instr[31:20]); S: sext({instr[31:25],instr[11:7]}); B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U: sext({instr[31:12],12'h000}); J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); sign extension to XLEN from instr[31].
REQ-018 R and ILLEGAL SHALL produce out_imm = 0.
REQ-019 Decode SHALL occur at acceptance; imm, fmt, tag stored in a 2-entry in-order skid buffer (count 0..2).
REQ-020 Accept when in_valid && in_ready; pop when out_valid && out_ready.
REQ-021 in_ready = (count != 2), derived from registered count only; no combinational path from out_ready.
REQ-022 out_valid = (count != 0); out_imm/out_fmt/out_tag SHALL show the oldest entry.
REQ-023 Latency: entry accepted at edge N visible on outputs after edge N (first cycle following) when buffer was empty.
REQ-024 Simultaneous push and pop at count 1 SHALL leave count 1 and present the new entry next cycle; at count 0 only push is possible, at count 2 only pop.
REQ-025 While out_valid && !out_ready, out_imm/out_fmt/out_tag SHALL remain stable.
REQ-026 Entry order SHALL be preserved; no entry dropped or duplicated.
REQ-027 err_cnt SHALL increment by 1 on each accepted ILLEGAL instruction, saturating at 16'hFFFF.
REQ-028 err_clr SHALL take priority over a same-cycle increment (result 0).

Reset
REQ-029 rst_n low SHALL asynchronously set count=0, in_ready=1 after release, out_valid=0, out_imm=0, out_fmt=0, out_tag=0, err_cnt=0.
REQ-030 Reset mid-operation SHALL discard all buffered entries; no entry emitted after release until a new acceptance.

Configuration
REQ-031 Macro IMMGEN_SHAMT_EN: when defined, opcode 0010011 with funct3 001 or 101 SHALL yield zero-extended shamt (instr[24:20] for XLEN=32, instr[25:20] for XLEN=64), fmt=I.
REQ-032 Without IMMGEN_SHAMT_EN those instructions SHALL use the plain I-type rule of REQ-017.

Verification
REQ-033 XLEN=32, in_instr 0xE0700013, out_ready=1 -> next cycle out_fmt=1, out_imm=0xFFFFFE07.
REQ-034 Sequence 0x00000163, 0x80000063, 0x12345037, 0x0040006F, 0x02000033 back-to-back, tags 1..5 -> outputs in order: B 0x00000002, B 0xFFFFF000, U 0x12345000, J 0x00000004, R 0x00000000, tags 1..5.
REQ-035 out_ready=0, push 3 instructions -> in_ready drops after 2 accepted, third held; raise out_ready -> all three emerge in order, outputs stable while stalled.
REQ-036 in_instr 0x4030D093 (SRAI) -> out_imm=0x00000403 without IMMGEN_SHAMT_EN, 0x00000003 with it; XLEN=64 I-type 0xFFF00013 -> 0xFFFFFFFFFFFFFFFF.
REQ-037 Push 3 words with opcode 0000000 -> err_cnt=3, out_fmt=7, out_imm=0; err_clr together with a 4th illegal push -> err_cnt=0.
REQ-038 Fill buffer to 2, assert rst_n low between edges -> out_valid=0 immediately, err_cnt=0; after release no stale entry emerges.
